// File: rtl/up5bit_counter_arbiter_if.sv
// Request/grant and shared-counter bus for the two-requester counter arbiter.
interface up5bit_counter_arbiter_if #(
  parameter int unsigned WIDTH = 5
);
  logic [1:0]       req;
  logic [WIDTH-1:0] tc0;
  logic [WIDTH-1:0] tc1;
  logic             en;
  logic [1:0]       gnt;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic [1:0]       done;

  modport master (
    output req, tc0, tc1, en,
    input  gnt, count, busy, done
  );

  modport slave (
    input  req, tc0, tc1, en,
    output gnt, count, busy, done
  );
endinterface

// File: rtl/up5bit_counter_arbiter.sv
// Round-robin arbiter granting a shared up-counter to one of two requesters;
// the winner's terminal count is latched at grant and a done pulse marks completion.
module up5bit_counter_arbiter #(
  parameter int unsigned WIDTH = 5
) (
  input logic                     clk,
  input logic                     reset,
  up5bit_counter_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q,  state_d;
  logic [1:0]       gnt_q,    gnt_d;
  logic [1:0]       done_q,   done_d;
  logic [WIDTH-1:0] count_q,  count_d;
  logic [WIDTH-1:0] tc_sel_q, tc_sel_d;
  logic             busy_q,   busy_d;
  logic             last_q,   last_d;
  logic             win_c;
  logic             owner_req_c;

  // Single requester always wins; on contention the one not granted last wins.
  always_comb begin
    win_c = ~last_q;
    if (bus.req == 2'b01) begin
      win_c = 1'b0;
    end else if (bus.req == 2'b10) begin
      win_c = 1'b1;
    end
  end

  assign owner_req_c = |(bus.req & gnt_q);

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    done_d   = 2'b00;
    count_d  = count_q;
    tc_sel_d = tc_sel_q;
    busy_d   = busy_q;
    last_d   = last_q;

    case (state_q)
      S_IDLE: begin
        gnt_d   = 2'b00;
        count_d = '0;
        busy_d  = 1'b0;
        if (bus.req != 2'b00) begin
          state_d  = S_COUNT;
          gnt_d    = win_c ? 2'b10 : 2'b01;
          tc_sel_d = win_c ? bus.tc1 : bus.tc0;
          last_d   = win_c;
          busy_d   = 1'b1;
        end
      end

      S_COUNT: begin
        // Abort outranks both the enable and a terminal match.
        if (!owner_req_c) begin
          state_d = S_IDLE;
          gnt_d   = 2'b00;
          count_d = '0;
          busy_d  = 1'b0;
        end else if (bus.en) begin
          if (count_q == tc_sel_q) begin
            state_d = S_DONE;
            done_d  = gnt_q;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = 2'b00;
        count_d = '0;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        gnt_d   = 2'b00;
        count_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // last_q resets to requester 1 so requester 0 takes the first contended grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      count_q  <= '0;
      tc_sel_q <= '0;
      busy_q   <= 1'b0;
      last_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      count_q  <= count_d;
      tc_sel_q <= tc_sel_d;
      busy_q   <= busy_d;
      last_q   <= last_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.done  = done_q;
  assign bus.count = count_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_up5bit_counter_arbiter.sv
// Self-checking bench for up5bit_counter_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_up5bit_counter_arbiter;
  localparam int unsigned WIDTH = 5;
  localparam int unsigned OW    = WIDTH + 5;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  up5bit_counter_arbiter_if #(.WIDTH(WIDTH)) bus ();
  up5bit_counter_arbiter #(.WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who owns the counter, its value, its limit, and whether
  // the completion cycle is being shown.
  int m_owner;
  int m_cnt;
  int m_tc;
  int m_last;
  bit m_fin;

  function automatic logic [OW-1:0] pk(logic [1:0] g, logic [WIDTH-1:0] c, logic b, logic [1:0] d);
    return {g, c, b, d};
  endfunction

  function automatic logic [OW-1:0] obs();
    return {bus.gnt, bus.count, bus.busy, bus.done};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req = 2'b00;
    bus.en  = 1'b0;
    #1 reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic model_step(input logic [1:0] req, input logic [WIDTH-1:0] tc0,
                            input logic [WIDTH-1:0] tc1, input logic en);
    if (m_fin) begin
      m_fin   = 1'b0;
      m_owner = -1;
      m_cnt   = 0;
    end else if (m_owner < 0) begin
      if (req != 2'b00) begin
        if (req == 2'b11) m_owner = 1 - m_last;
        else              m_owner = req[1] ? 1 : 0;
        m_last = m_owner;
        m_tc   = (m_owner == 1) ? int'(tc1) : int'(tc0);
        m_cnt  = 0;
      end
    end else if (!req[m_owner]) begin
      m_owner = -1;
      m_cnt   = 0;
    end else if (en) begin
      if (m_cnt == m_tc) m_fin = 1'b1;
      else               m_cnt = m_cnt + 1;
    end
  endtask

  task automatic test_reset();
    logic [OW-1:0] o;
    bus.req = 2'b11; bus.tc0 = '0; bus.tc1 = '0; bus.en = 1'b1;
    reset = 1'b1;
    #2 reset = 1'b0;
    tick();
    o = obs(); n_checks++;
    if (o !== pk(2'b00, '0, 1'b0, 2'b00)) begin
      n_fail++; $display("FAIL reset_state: got %h want %h", o, pk(2'b00, '0, 1'b0, 2'b00));
    end
    bus.req = 2'b00;
    tick();
    reset = 1'b1;
    tick();
    o = obs(); n_checks++;
    if (o !== pk(2'b00, '0, 1'b0, 2'b00)) begin
      n_fail++; $display("FAIL idle_after_reset: got %h want %h", o, pk(2'b00, '0, 1'b0, 2'b00));
    end
  endtask

  task automatic test_single();
    logic [OW-1:0] o, e;
    bus.req = 2'b01; bus.tc0 = 5'd5; bus.en = 1'b1;
    tick();
    o = obs(); e = pk(2'b01, '0, 1'b1, 2'b00); n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL single_grant: got %h want %h", o, e); end
    for (int i = 1; i <= 5; i++) begin
      tick();
      o = obs(); e = pk(2'b01, WIDTH'(i), 1'b1, 2'b00); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL single_count%0d: got %h want %h", i, o, e); end
    end
    tick();
    o = obs(); e = pk(2'b01, 5'd5, 1'b1, 2'b01); n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL single_done: got %h want %h", o, e); end
    bus.req = 2'b00;
    tick();
    o = obs(); e = pk(2'b00, '0, 1'b0, 2'b00); n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL single_idle: got %h want %h", o, e); end
  endtask

  task automatic test_contention();
    logic [OW-1:0] o, e;
    logic [1:0] exp_g [3] = '{2'b01, 2'b10, 2'b01};
    int         exp_tc[3] = '{2, 3, 2};
    int n;
    do_reset();
    bus.req = 2'b11; bus.tc0 = 5'd2; bus.tc1 = 5'd3; bus.en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      o = obs(); e = pk(exp_g[k], '0, 1'b1, 2'b00); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL contention_grant%0d: got %h want %h", k, o, e); end
      n = 0;
      while (bus.done == 2'b00 && n < 40) begin
        n++;
        tick();
      end
      n_checks++;
      if (n != exp_tc[k] + 1) begin
        n_fail++; $display("FAIL contention_cycles%0d: got %0d want %0d", k, n, exp_tc[k] + 1);
      end
      o = obs(); e = pk(exp_g[k], WIDTH'(exp_tc[k]), 1'b1, exp_g[k]); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL contention_done%0d: got %h want %h", k, o, e); end
      if (k == 2) bus.req = 2'b00;
      tick();
      o = obs(); e = pk(2'b00, '0, 1'b0, 2'b00); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL contention_idle%0d: got %h want %h", k, o, e); end
    end
  endtask

  task automatic test_stall_abort();
    logic [OW-1:0] o, e;
    bus.req = 2'b10; bus.tc1 = 5'd31; bus.en = 1'b1;
    tick();
    o = obs(); e = pk(2'b10, '0, 1'b1, 2'b00); n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL stall_grant: got %h want %h", o, e); end
    for (int i = 1; i <= 7; i++) begin
      bus.en = 1'b1;
      tick();
      if (i == 3) begin
        bus.en = 1'b0;
        for (int h = 0; h < 3; h++) begin
          tick();
          o = obs(); e = pk(2'b10, 5'd3, 1'b1, 2'b00); n_checks++;
          if (o !== e) begin n_fail++; $display("FAIL stall_hold%0d: got %h want %h", h, o, e); end
        end
      end else begin
        o = obs(); e = pk(2'b10, WIDTH'(i), 1'b1, 2'b00); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL stall_count%0d: got %h want %h", i, o, e); end
      end
    end
    bus.en = 1'b1;
    bus.req = 2'b00;
    tick();
    o = obs(); e = pk(2'b00, '0, 1'b0, 2'b00); n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL abort_idle: got %h want %h", o, e); end
    tick();
    o = obs(); n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL abort_no_done: got %h want %h", o, e); end
  endtask

  task automatic test_boundaries();
    logic [OW-1:0] o, e;
    bus.req = 2'b01; bus.tc0 = 5'd0; bus.en = 1'b1;
    tick();
    o = obs(); e = pk(2'b01, '0, 1'b1, 2'b00); n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL tc0_grant: got %h want %h", o, e); end
    tick();
    o = obs(); e = pk(2'b01, '0, 1'b1, 2'b01); n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL tc0_done: got %h want %h", o, e); end
    bus.req = 2'b00;
    tick();
    bus.req = 2'b10; bus.tc1 = 5'd31;
    tick();
    bus.tc1 = 5'd3;
    for (int i = 1; i <= 31; i++) begin
      tick();
      bus.tc1 = WIDTH'($urandom_range(0, 31));
      o = obs(); e = pk(2'b10, WIDTH'(i), 1'b1, 2'b00); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL tcmax_count%0d: got %h want %h", i, o, e); end
    end
    tick();
    o = obs(); e = pk(2'b10, 5'd31, 1'b1, 2'b10); n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL tcmax_done: got %h want %h", o, e); end
    bus.req = 2'b00;
    tick();
    o = obs(); e = pk(2'b00, '0, 1'b0, 2'b00); n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL tcmax_idle: got %h want %h", o, e); end
  endtask

  task automatic test_mid_reset();
    logic [OW-1:0] o, e;
    bus.req = 2'b01; bus.tc0 = 5'd20; bus.en = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) tick();
    o = obs(); e = pk(2'b01, 5'd10, 1'b1, 2'b00); n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL midreset_pre: got %h want %h", o, e); end
    #2 reset = 1'b0;
    #1;
    o = obs(); e = pk(2'b00, '0, 1'b0, 2'b00); n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL midreset_async: got %h want %h", o, e); end
    bus.req = 2'b11;
    tick();
    reset = 1'b1;
    tick();
    o = obs(); e = pk(2'b01, '0, 1'b1, 2'b00); n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL midreset_first_grant: got %h want %h", o, e); end
    bus.req = 2'b00;
    tick();
  endtask

  task automatic test_random();
    logic [OW-1:0] o, e;
    logic [1:0] g;
    do_reset();
    m_owner = -1; m_cnt = 0; m_tc = 0; m_last = 1; m_fin = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if ($urandom_range(0, 7) == 0) bus.req = 2'($urandom_range(0, 3));
      bus.en  = ($urandom_range(0, 3) != 0);
      bus.tc0 = $urandom_range(0, 1) ? WIDTH'($urandom_range(0, 6)) : WIDTH'($urandom_range(0, 31));
      bus.tc1 = $urandom_range(0, 1) ? WIDTH'($urandom_range(0, 6)) : WIDTH'($urandom_range(0, 31));
      model_step(bus.req, bus.tc0, bus.tc1, bus.en);
      tick();
      g = (m_owner < 0) ? 2'b00 : ((m_owner == 1) ? 2'b10 : 2'b01);
      e = pk(g, WIDTH'(m_cnt), (m_owner >= 0), m_fin ? g : 2'b00);
      o = obs(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL random_cycle%0d: got %h want %h", c, o, e); end
      n_checks++;
      if (!(bus.gnt != 2'b11 && (bus.done == 2'b00 || bus.done == bus.gnt))) begin
        n_fail++; $display("FAIL random_invariant%0d: got gnt=%b done=%b want onehot0 and done in {0,gnt}", c, bus.gnt, bus.done);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_stall_abort();
    test_boundaries();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
